// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter and its debug write FIFO.
package mem_arb_pkg;

    localparam int DEF_AW        = 16;
    localparam int DEF_DW        = 16;
    localparam int DEF_DBG_DEPTH = 2;
    localparam int DEF_WAIT_MAX  = 15;

    typedef enum logic [2:0] {
        GNT_NONE = 3'd0,
        GNT_INS  = 3'd1,
        GNT_DRD  = 3'd2,
        GNT_DWR  = 3'd3,
        GNT_DBG  = 3'd4
    } grant_e;

    typedef enum logic {
        CLS_INS = 1'b0,
        CLS_DAT = 1'b1
    } cls_e;

endpackage

// File: rtl/dbg_wr_fifo.sv
// Posted debug write buffer: DEPTH entries of {addr, data}, head visible combinationally.
module dbg_wr_fifo
    import mem_arb_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DBG_DEPTH
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full      = (count_q == (PW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign do_pop    = pop && !empty;
    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_addr = addr_mem[rd_ptr_q];
    assign head_data = data_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr_q] <= push_addr;
            data_mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: debug posted writes, then round-robin CPU instruction/data access.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int DBG_DEPTH = DEF_DBG_DEPTH,
    parameter int WAIT_MAX  = DEF_WAIT_MAX
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] ins_rd_addr,
    input  logic          ins_rd_req,
    output logic          ins_rd_rdy,
    output logic [DW-1:0] ins_rd_data,
    input  logic [AW-1:0] dat_rw_addr,
    input  logic [DW-1:0] dat_wr_data,
    input  logic          dat_rd_req,
    output logic          dat_rd_rdy,
    output logic [DW-1:0] dat_rd_data,
    input  logic          dat_wr_req,
    output logic          dat_wr_rdy,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_waddr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata
);

    localparam int AGW = $clog2(WAIT_MAX + 1);

    // Handshake: req with stable addr/data; a grant in cycle T is one access, the
    // matching rdy pulses in T+1 only (read data = mem_rdata then); req held across
    // rdy is a new access with a new address, and denied requests simply wait.

    grant_e        gnt;
    grant_e        dat_gnt;
    cls_e          rr_last_q, rr_last_d;
    logic [AGW-1:0] age_q, age_d;
    logic          ins_rdy_q, drd_rdy_q, dwr_rdy_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          fifo_full, fifo_empty, fifo_pop;
    logic [AW-1:0] fifo_head_addr;
    logic [DW-1:0] fifo_head_data;
    logic          cpu_req, dat_req, dbg_force;

    dbg_wr_fifo #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DBG_DEPTH)
    ) u_dbg_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (dbg_we),
        .push_addr (dbg_waddr),
        .push_data (dbg_wdata),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_addr (fifo_head_addr),
        .head_data (fifo_head_data)
    );

    assign dat_req   = dat_rd_req || dat_wr_req;
    assign cpu_req   = ins_rd_req || dat_req;
    assign dbg_force = fifo_full || (age_q == AGW'(WAIT_MAX));
    assign dat_gnt   = dat_wr_req ? GNT_DWR : GNT_DRD;
    assign fifo_pop  = (gnt == GNT_DBG);

    // Grant is held off while reset is asserted so mem_* show reset values.
    always_comb begin
        gnt = GNT_NONE;
        if (!reset_n) begin
            gnt = GNT_NONE;
        end else if (!fifo_empty && (dbg_force || !cpu_req)) begin
            gnt = GNT_DBG;
        end else if (ins_rd_req && dat_req) begin
            gnt = (rr_last_q == CLS_INS) ? dat_gnt : GNT_INS;
        end else if (ins_rd_req) begin
            gnt = GNT_INS;
        end else if (dat_req) begin
            gnt = dat_gnt;
        end
    end

    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (gnt)
            GNT_INS: begin
                mem_addr = ins_rd_addr;
                mem_re   = 1'b1;
            end
            GNT_DRD: begin
                mem_addr = dat_rw_addr;
                mem_re   = 1'b1;
            end
            GNT_DWR: begin
                mem_addr  = dat_rw_addr;
                mem_wdata = dat_wr_data;
                mem_we    = 1'b1;
            end
            GNT_DBG: begin
                mem_addr  = fifo_head_addr;
                mem_wdata = fifo_head_data;
                mem_we    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (gnt == GNT_INS) begin
            rr_last_d = CLS_INS;
        end else if (gnt == GNT_DRD || gnt == GNT_DWR) begin
            rr_last_d = CLS_DAT;
        end
        if (fifo_pop || fifo_empty) begin
            age_d = '0;
        end else if (age_q == AGW'(WAIT_MAX)) begin
            age_d = age_q;
        end else begin
            age_d = age_q + AGW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last_q <= CLS_DAT;
            age_q     <= '0;
            ins_rdy_q <= 1'b0;
            drd_rdy_q <= 1'b0;
            dwr_rdy_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            rr_last_q <= rr_last_d;
            age_q     <= age_d;
            ins_rdy_q <= (gnt == GNT_INS);
            drd_rdy_q <= (gnt == GNT_DRD);
            dwr_rdy_q <= (gnt == GNT_DWR);
            addr_q    <= mem_addr;
            wdata_q   <= mem_wdata;
        end
    end

    assign ins_rd_rdy  = ins_rdy_q;
    assign dat_rd_rdy  = drd_rdy_q;
    assign dat_wr_rdy  = dwr_rdy_q;
    assign ins_rd_data = mem_rdata;
    assign dat_rd_data = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: queue-based reference model checked every cycle, plus directed literal checks.
module tb_mem_arbiter;

    localparam int AW        = 16;
    localparam int DW        = 16;
    localparam int DBG_DEPTH = 2;
    localparam int WAIT_MAX  = 15;

    localparam int G_NONE = 0;
    localparam int G_INS  = 1;
    localparam int G_DRD  = 2;
    localparam int G_DWR  = 3;
    localparam int G_DBG  = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] ins_rd_addr = '0;
    logic          ins_rd_req = 1'b0;
    logic          ins_rd_rdy;
    logic [DW-1:0] ins_rd_data;
    logic [AW-1:0] dat_rw_addr = '0;
    logic [DW-1:0] dat_wr_data = '0;
    logic          dat_rd_req = 1'b0;
    logic          dat_rd_rdy;
    logic [DW-1:0] dat_rd_data;
    logic          dat_wr_req = 1'b0;
    logic          dat_wr_rdy;
    logic          dbg_we = 1'b0;
    logic [AW-1:0] dbg_waddr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata = '0;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(
        .AW        (AW),
        .DW        (DW),
        .DBG_DEPTH (DBG_DEPTH),
        .WAIT_MAX  (WAIT_MAX)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ins_rd_addr (ins_rd_addr),
        .ins_rd_req  (ins_rd_req),
        .ins_rd_rdy  (ins_rd_rdy),
        .ins_rd_data (ins_rd_data),
        .dat_rw_addr (dat_rw_addr),
        .dat_wr_data (dat_wr_data),
        .dat_rd_req  (dat_rd_req),
        .dat_rd_rdy  (dat_rd_rdy),
        .dat_rd_data (dat_rd_data),
        .dat_wr_req  (dat_wr_req),
        .dat_wr_rdy  (dat_wr_rdy),
        .dbg_we      (dbg_we),
        .dbg_waddr   (dbg_waddr),
        .dbg_wdata   (dbg_wdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata)
    );

    // ---------------- clock / memory model ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem_addr ^ 16'hA5A5;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model state ----------------
    logic [31:0] dq[$];
    int          head_wait;
    bit          rr_dat;
    bit          e_ins_rdy, e_drd_rdy, e_dwr_rdy;
    logic [15:0] last_addr, last_wdata, last_rd_addr;
    logic [15:0] e_addr, e_wdata;
    bit          e_we, e_re;
    int          g;
    bit          s_dbg_we;
    logic [15:0] s_dbg_waddr, s_dbg_wdata;

    // observation logs for directed checks
    logic [31:0] wr_log[$];
    logic [15:0] ins_data_log[$];
    logic [15:0] rd_addr_log[$];
    int          rdy_pulses;

    task automatic clear_logs();
        wr_log.delete();
        ins_data_log.delete();
        rd_addr_log.delete();
        rdy_pulses = 0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                dq.delete();
                head_wait    = 0;
                rr_dat       = 1'b1;
                e_ins_rdy    = 1'b0;
                e_drd_rdy    = 1'b0;
                e_dwr_rdy    = 1'b0;
                last_addr    = '0;
                last_wdata   = '0;
                last_rd_addr = '0;
                check("rst_ins_rdy", 32'(ins_rd_rdy), 32'd0);
                check("rst_drd_rdy", 32'(dat_rd_rdy), 32'd0);
                check("rst_dwr_rdy", 32'(dat_wr_rdy), 32'd0);
                check("rst_mem_we", 32'(mem_we), 32'd0);
                check("rst_mem_re", 32'(mem_re), 32'd0);
                check("rst_mem_addr", 32'(mem_addr), 32'd0);
                check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
            end else begin
                // expected grant from the arbitration rules
                if (dq.size() > 0 && (dq.size() == DBG_DEPTH || head_wait >= WAIT_MAX ||
                    !(ins_rd_req || dat_rd_req || dat_wr_req))) begin
                    g = G_DBG;
                end else if (ins_rd_req && (dat_rd_req || dat_wr_req)) begin
                    g = rr_dat ? G_INS : (dat_wr_req ? G_DWR : G_DRD);
                end else if (ins_rd_req) begin
                    g = G_INS;
                end else if (dat_wr_req) begin
                    g = G_DWR;
                end else if (dat_rd_req) begin
                    g = G_DRD;
                end else begin
                    g = G_NONE;
                end
                e_we    = (g == G_DWR || g == G_DBG);
                e_re    = (g == G_INS || g == G_DRD);
                e_addr  = last_addr;
                e_wdata = last_wdata;
                if (g == G_INS) e_addr = ins_rd_addr;
                if (g == G_DRD || g == G_DWR) e_addr = dat_rw_addr;
                if (g == G_DWR) e_wdata = dat_wr_data;
                if (g == G_DBG) begin
                    e_addr  = dq[0][31:16];
                    e_wdata = dq[0][15:0];
                end
                check("mem_we", 32'(mem_we), 32'(e_we));
                check("mem_re", 32'(mem_re), 32'(e_re));
                check("mem_addr", 32'(mem_addr), 32'(e_addr));
                if (!e_re) check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
                check("ins_rd_rdy", 32'(ins_rd_rdy), 32'(e_ins_rdy));
                check("dat_rd_rdy", 32'(dat_rd_rdy), 32'(e_drd_rdy));
                check("dat_wr_rdy", 32'(dat_wr_rdy), 32'(e_dwr_rdy));
                if (e_ins_rdy) check("ins_rd_data", 32'(ins_rd_data), 32'(last_rd_addr ^ 16'hA5A5));
                if (e_drd_rdy) check("dat_rd_data", 32'(dat_rd_data), 32'(last_rd_addr ^ 16'hA5A5));

                if (mem_we) wr_log.push_back({mem_addr, mem_wdata});
                if (mem_re) rd_addr_log.push_back(mem_addr);
                if (ins_rd_rdy) ins_data_log.push_back(ins_rd_data);
                if (ins_rd_rdy || dat_rd_rdy || dat_wr_rdy) rdy_pulses++;

                s_dbg_we    = dbg_we;
                s_dbg_waddr = dbg_waddr;
                s_dbg_wdata = dbg_wdata;

                @(posedge clk);
                if (reset_n) begin
                    if (g == G_DBG) begin
                        void'(dq.pop_front());
                        head_wait = 0;
                    end else if (dq.size() > 0 && head_wait < WAIT_MAX) begin
                        head_wait++;
                    end
                    if (s_dbg_we) dq.push_back({s_dbg_waddr, s_dbg_wdata});
                    if (g == G_INS) rr_dat = 1'b0;
                    if (g == G_DRD || g == G_DWR) rr_dat = 1'b1;
                    e_ins_rdy = (g == G_INS);
                    e_drd_rdy = (g == G_DRD);
                    e_dwr_rdy = (g == G_DWR);
                    if (g != G_NONE) last_addr = e_addr;
                    if (e_we) last_wdata = e_wdata;
                    if (e_re) last_rd_addr = e_addr;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        ins_rd_req = 1'b0;
        dat_rd_req = 1'b0;
        dat_wr_req = 1'b0;
        dbg_we     = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic random_phase(input int cycles, input int cpu_load);
        for (int c = 0; c < cycles; c++) begin
            ins_rd_req  = ($urandom_range(0, 7) < cpu_load);
            ins_rd_addr = 16'($urandom_range(0, 65535));
            dat_rd_req  = ($urandom_range(0, 7) < cpu_load);
            dat_wr_req  = ($urandom_range(0, 7) < cpu_load / 2);
            dat_rw_addr = 16'($urandom_range(0, 65535));
            dat_wr_data = 16'($urandom_range(0, 65535));
            dbg_we      = ($urandom_range(0, 4) == 0);
            dbg_waddr   = 16'($urandom_range(0, 65535));
            dbg_wdata   = 16'($urandom_range(0, 65535));
            tick();
        end
        idle_inputs();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        clear_logs();
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // reset release, nothing requested
        repeat (10) tick();
        check("p1_rdy_pulses", 32'(rdy_pulses), 32'd0);
        check("p1_mem_addr", 32'(mem_addr), 32'd0);
        check("p1_writes", 32'(wr_log.size()), 32'd0);

        // streaming instruction fetch 0x10..0x13
        clear_logs();
        ins_rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ins_rd_addr = 16'h0010 + 16'(i);
            tick();
        end
        ins_rd_req = 1'b0;
        tick();
        tick();
        check("p2_count", 32'(ins_data_log.size()), 32'd4);
        if (ins_data_log.size() == 4) begin
            check("p2_data0", 32'(ins_data_log[0]), 32'h0000A5B5);
            check("p2_data1", 32'(ins_data_log[1]), 32'h0000A5B4);
            check("p2_data2", 32'(ins_data_log[2]), 32'h0000A5B7);
            check("p2_data3", 32'(ins_data_log[3]), 32'h0000A5B6);
        end

        // ins/dat contention after reset: ins first, then alternate
        do_reset();
        clear_logs();
        ins_rd_addr = 16'h0100;
        dat_rw_addr = 16'h0200;
        ins_rd_req  = 1'b1;
        dat_rd_req  = 1'b1;
        repeat (4) tick();
        idle_inputs();
        tick();
        tick();
        check("p3_count", 32'(rd_addr_log.size()), 32'd4);
        if (rd_addr_log.size() == 4) begin
            check("p3_g0", 32'(rd_addr_log[0]), 32'h0100);
            check("p3_g1", 32'(rd_addr_log[1]), 32'h0200);
            check("p3_g2", 32'(rd_addr_log[2]), 32'h0100);
            check("p3_g3", 32'(rd_addr_log[3]), 32'h0200);
        end

        // single debug write with CPU idle
        clear_logs();
        dbg_we    = 1'b1;
        dbg_waddr = 16'h0020;
        dbg_wdata = 16'h1234;
        tick();
        dbg_we = 1'b0;
        @(negedge clk);
        check("p4_we", 32'(mem_we), 32'd1);
        check("p4_addr", 32'(mem_addr), 32'h0020);
        check("p4_wdata", 32'(mem_wdata), 32'h1234);
        repeat (3) tick();
        check("p4_writes", 32'(wr_log.size()), 32'd1);
        check("p4_rdy_pulses", 32'(rdy_pulses), 32'd0);

        // CPU saturated: full FIFO forces a debug grant, age drains the second entry
        clear_logs();
        ins_rd_addr = 16'h0300;
        dat_rw_addr = 16'h0400;
        ins_rd_req  = 1'b1;
        dat_rd_req  = 1'b1;
        dbg_we      = 1'b1;
        dbg_waddr   = 16'h0030;
        dbg_wdata   = 16'h1111;
        tick();
        dbg_waddr = 16'h0031;
        dbg_wdata = 16'h2222;
        tick();
        dbg_we = 1'b0;
        @(negedge clk);
        check("p5_forced_we", 32'(mem_we), 32'd1);
        check("p5_forced_addr", 32'(mem_addr), 32'h0030);
        for (int c = 0; c < 40 && wr_log.size() < 2; c++) tick();
        check("p5_writes", 32'(wr_log.size()), 32'd2);
        if (wr_log.size() == 2) begin
            check("p5_w0", wr_log[0], 32'h00301111);
            check("p5_w1", wr_log[1], 32'h00312222);
        end
        idle_inputs();
        tick();
        tick();

        // write beats read; async reset in the rdy cycle discards the queued debug write
        do_reset();
        clear_logs();
        dat_rw_addr = 16'h0040;
        dat_wr_data = 16'hBEEF;
        dat_wr_req  = 1'b1;
        dat_rd_req  = 1'b1;
        dbg_we      = 1'b1;
        dbg_waddr   = 16'h0050;
        dbg_wdata   = 16'h5555;
        tick();
        dat_wr_req = 1'b0;
        dbg_we     = 1'b0;
        check("p6_wr_rdy", 32'(dat_wr_rdy), 32'd1);
        check("p6_first_write", 32'(wr_log.size()), 32'd1);
        if (wr_log.size() == 1) check("p6_write_val", wr_log[0], 32'h0040BEEF);
        #1 reset_n = 1'b0;
        #1;
        check("p6_rdy_async", 32'(dat_wr_rdy), 32'd0);
        check("p6_re_in_reset", 32'(mem_re), 32'd0);
        idle_inputs();
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (25) tick();
        check("p6_dbg_discarded", 32'(wr_log.size()), 32'd1);

        // randomized traffic, light then heavy CPU load
        random_phase(1500, 4);
        random_phase(1500, 7);
        repeat (40) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
